// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: PC register and instruction-fetch sequencer between the next-PC generator and decode
module ifu_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          XLEN     = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] next_pc,
    input  logic            next_pc_valid,
    output logic [XLEN-1:0] pc_out,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_misalign
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_EXEC, S_HALT} state_t;

    state_t          state_q, state_d, commit_tgt;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            misalign_q, misalign_d;
    logic            commit;

    // next state, PC load on commit, instruction capture in S_WAIT, sticky misalign
    always_comb begin
        commit     = (state_q == S_OUT && inst_ready && next_pc_valid) || (state_q == S_EXEC && next_pc_valid);
        commit_tgt = (next_pc[1:0] != 2'b00) ? S_HALT : S_REQ;
        pc_d       = commit ? next_pc : pc_q;
        misalign_d = misalign_q | (commit && next_pc[1:0] != 2'b00);
        inst_d     = (state_q == S_WAIT && imem_resp_valid) ? (pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0]) : inst_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   state_d = imem_req_ready ? S_WAIT : S_REQ;
            S_WAIT:  state_d = imem_resp_valid ? S_OUT : S_WAIT;
            S_OUT:   state_d = commit ? commit_tgt : (inst_ready ? S_EXEC : S_OUT);
            S_EXEC:  state_d = commit ? commit_tgt : S_EXEC;
            default: state_d = S_HALT;
        endcase
    end

    // state registers; reset abandons any outstanding request or response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_out         = pc_q;
    assign imem_req_valid = state_q == S_REQ;
    assign imem_req_addr  = {pc_q[XLEN-1:3], 3'b000};
    assign inst_valid     = state_q == S_OUT;
    assign inst           = inst_q;
    assign inst_pc        = pc_q;
    assign fetch_misalign = misalign_q;
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed vector table plus hand sequences for stall, split commit, halt and reset
module tb_ifu_fetch_ctrl;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] next_pc = '0;
    logic        next_pc_valid = 1'b0;
    logic [63:0] pc_out;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [63:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        fetch_misalign;

    int checks = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] data;
        logic [31:0] exp_inst;
        logic [63:0] npc;
    } vec_t;

    vec_t vecs[5];

    ifu_fetch_ctrl #(.RESET_PC(RST_PC), .XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .next_pc_valid(next_pc_valid),
        .pc_out(pc_out), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // entry: at negedge in S_REQ; exit: at negedge in S_OUT
    task automatic do_fetch(input logic [63:0] pc, input logic [63:0] data, input logic [31:0] exp_inst);
        chk("req_valid", imem_req_valid, 1);
        chk("req_addr", imem_req_addr, {pc[63:3], 3'b000});
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk("req_drop_in_wait", imem_req_valid, 0);
        imem_resp_valid = 1'b1;
        imem_resp_data = data;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data = 64'hbad0_bad0_bad0_bad0;
        chk("inst_valid", inst_valid, 1);
        chk("inst", inst, exp_inst);
        chk("inst_pc", inst_pc, pc);
    endtask

    task automatic commit_fused(input logic [63:0] npc);
        inst_ready = 1'b1;
        next_pc_valid = 1'b1;
        next_pc = npc;
        @(negedge clk);
        inst_ready = 1'b0;
        next_pc_valid = 1'b0;
        chk("pc_after_commit", pc_out, npc);
        chk("inst_valid_after_commit", inst_valid, 0);
        chk("req_after_commit", imem_req_valid, npc[1:0] == 2'b00);
    endtask

    initial begin
        vecs[0] = '{64'h8000_0000, 64'h00100093_00000013, 32'h00000013, 64'h8000_0004};
        vecs[1] = '{64'h8000_0004, 64'h00100093_00000013, 32'h00100093, 64'h8000_0100};
        vecs[2] = '{64'h8000_0100, 64'hdeadbeef_cafef00d, 32'hcafef00d, 64'h8000_010c};
        vecs[3] = '{64'h8000_010c, 64'h11112222_33334444, 32'h11112222, 64'h0000_0000};
        vecs[4] = '{64'h0000_0000, 64'haaaaaaaa_55555555, 32'h55555555, 64'h8000_0008};

        repeat (2) @(negedge clk);
        chk("rst_pc", pc_out, RST_PC);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_misalign", fetch_misalign, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, RST_PC);
        chk("first_inst_valid", inst_valid, 0);

        for (int i = 0; i < 5; i++) begin
            chk("vec_pc", pc_out, vecs[i].pc);
            do_fetch(vecs[i].pc, vecs[i].data, vecs[i].exp_inst);
            commit_fused(vecs[i].npc);
        end

        // stall in S_REQ with a spurious response and an ignored commit strobe
        for (int i = 0; i < 5; i++) begin
            imem_resp_valid = (i == 2);
            imem_resp_data = 64'h12345678_9abcdef0;
            next_pc_valid = (i == 3);
            next_pc = 64'h4000_0000;
            @(negedge clk);
            chk("stall_req_valid", imem_req_valid, 1);
            chk("stall_req_addr", imem_req_addr, 64'h8000_0008);
        end
        imem_resp_valid = 1'b0;
        next_pc_valid = 1'b0;
        chk("stall_inst_kept", inst, 32'h55555555);
        chk("stall_pc_kept", pc_out, 64'h8000_0008);
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("one_accept", imem_req_valid, 0);
        @(negedge clk);
        chk("no_second_accept", imem_req_valid, 0);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 64'h0badf00d_00a00513;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        chk("stall_inst", inst, 32'h00a00513);
        chk("stall_inst_valid", inst_valid, 1);

        // decode accepts, execute commits three cycles later
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("exec_inst_valid", inst_valid, 0);
            chk("exec_req_valid", imem_req_valid, 0);
            chk("exec_pc", pc_out, 64'h8000_0008);
            @(negedge clk);
        end
        next_pc_valid = 1'b1;
        next_pc = 64'h8000_0100;
        @(negedge clk);
        next_pc_valid = 1'b0;
        chk("late_commit_pc", pc_out, 64'h8000_0100);
        chk("late_commit_req", imem_req_valid, 1);
        chk("late_commit_addr", imem_req_addr, 64'h8000_0100);

        // misaligned target halts the sequencer
        do_fetch(64'h8000_0100, 64'hdeadbeef_cafef00d, 32'hcafef00d);
        commit_fused(64'h8000_0102);
        chk("misalign_set", fetch_misalign, 1);
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        next_pc_valid = 1'b1;
        next_pc = 64'h8000_0200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_req_valid", imem_req_valid, 0);
            chk("halt_inst_valid", inst_valid, 0);
            chk("halt_pc", pc_out, 64'h8000_0102);
            chk("halt_misalign", fetch_misalign, 1);
        end
        imem_req_ready = 1'b0;
        inst_ready = 1'b0;
        next_pc_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("halt_rst_pc", pc_out, RST_PC);
        chk("halt_rst_misalign", fetch_misalign, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_halt_req", imem_req_valid, 1);

        // reset during S_WAIT, stale response held off to S_REQ of the fresh fetch
        do_fetch(RST_PC, 64'h00100093_00000013, 32'h00000013);
        commit_fused(64'h8000_0004);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("wait_rst_pc", pc_out, RST_PC);
        chk("wait_rst_req", imem_req_valid, 0);
        chk("wait_rst_inst", inst, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_resp_valid = 1'b1;
        imem_resp_data = 64'hffffffff_eeeeeeee;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        chk("stale_ignored_inst", inst, 0);
        chk("stale_req_valid", imem_req_valid, 1);
        do_fetch(RST_PC, 64'h00200113_00300193, 32'h00300193);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
